// File: rtl/mem_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_sync_pkg
// Purpose  : Shared definitions for the row-cache sync controller.
//            - Timing-FSM state codes seen on BankFSM and small decode helpers.
//            - Per-bank controller state (bank_state_e).
//            - Cache tag record (tag_t) and a saturating adder for the
//              optional event counters (MEMSYNC_PERF_EN).
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package mem_sync_pkg;

    // Timing-FSM state codes
    localparam logic [4:0] c_fsm_act = 5'b00001;
    localparam logic [4:0] c_fsm_pr  = 5'b01010;
    localparam logic [4:0] c_fsm_rd0 = 5'b01011;
    localparam logic [4:0] c_fsm_rd1 = 5'b01100;
    localparam logic [4:0] c_fsm_wr0 = 5'b10010;
    localparam logic [4:0] c_fsm_wr1 = 5'b10011;

    // Row width held in a tag; the top-level ADDRWIDTH defaults to this.
    localparam int c_row_w = 17;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } bank_state_e;

    typedef struct packed {
        logic               valid;
        logic               dirty;
        logic [c_row_w-1:0] row;
    } tag_t;

    function automatic logic fsm_is_act(input logic [4:0] s);
        return s == c_fsm_act;
    endfunction

    function automatic logic fsm_is_pr(input logic [4:0] s);
        return s == c_fsm_pr;
    endfunction

    function automatic logic fsm_is_rd(input logic [4:0] s);
        return (s == c_fsm_rd0) || (s == c_fsm_rd1);
    endfunction

    function automatic logic fsm_is_wr(input logic [4:0] s);
        return (s == c_fsm_wr0) || (s == c_fsm_wr1);
    endfunction

    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_sync_bank.sv
`default_nettype none
// ============================================================================
// Module   : mem_sync_bank
// Purpose  : Row-cache bookkeeping for one DRAM bank: tag table, round-robin
//            victim pointer, IDLE/WB/FILL controller, open-slot tracking and
//            the transfer request + payload presented to the arbiter.
// Ports    : clk, reset_n          clock, async active-low reset
//            i_row_id, i_bank_fsm  row address and timing-FSM state
//            i_ack                 completion of this bank's granted transfer
//            o_req/o_wb/o_row/o_slot  transfer request and payload
//            o_crow_id, o_stall    open cache slot, registered bank stall
//            o_hit/o_miss/o_wb_done  event pulses (only with MEMSYNC_PERF_EN)
// Revision : 1.0  initial release
// ============================================================================
module mem_sync_bank
    import mem_sync_pkg::*;
#(
    parameter int CHWIDTH   = 5,
    parameter int ADDRWIDTH = c_row_w
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [ADDRWIDTH-1:0] i_row_id,
    input  logic [4:0]           i_bank_fsm,
    input  logic                 i_ack,
    output logic                 o_req,
    output logic                 o_wb,
    output logic [ADDRWIDTH-1:0] o_row,
    output logic [CHWIDTH-1:0]   o_slot,
    output logic [CHWIDTH-1:0]   o_crow_id,
    output logic                 o_stall
`ifdef MEMSYNC_PERF_EN
    ,
    output logic                 o_hit,
    output logic                 o_miss,
    output logic                 o_wb_done
`endif
);

    localparam int c_chrows = 2**CHWIDTH;

    bank_state_e          r_state;
    bank_state_e          w_state_nxt;
    tag_t                 r_tags [c_chrows];
    logic [CHWIDTH-1:0]   r_rr_ptr;
    logic [CHWIDTH-1:0]   r_slot;
    logic [CHWIDTH-1:0]   r_crow_id;
    logic [ADDRWIDTH-1:0] r_row;
    logic [ADDRWIDTH-1:0] r_wb_row;
    logic [4:0]           r_prev_fsm;
    logic                 r_open;
    logic                 r_close_pend;
    logic                 r_stall;

    logic                 w_act_evt;
    logic                 w_is_pr;
    logic                 w_is_wr;
    logic                 w_hit;
    logic [CHWIDTH-1:0]   w_hit_slot;
    logic                 w_has_free;
    logic [CHWIDTH-1:0]   w_free_slot;
    logic [CHWIDTH-1:0]   w_victim;
    logic                 w_victim_dirty;
    logic                 w_hit_evt;
    logic                 w_miss_evt;
    logic                 w_fill_done;

    // A held ACT counts once: only the transition into ACT is an event.
    assign w_act_evt = fsm_is_act(i_bank_fsm) && !fsm_is_act(r_prev_fsm);
    assign w_is_pr   = fsm_is_pr(i_bank_fsm);
    assign w_is_wr   = fsm_is_wr(i_bank_fsm);

    // Tag lookup. Descending scan so the lowest matching/free index wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_slot  = '0;
        w_has_free  = 1'b0;
        w_free_slot = '0;
        for (int i = c_chrows - 1; i >= 0; i--) begin
            if (r_tags[i].valid && (r_tags[i].row == i_row_id)) begin
                w_hit      = 1'b1;
                w_hit_slot = i[CHWIDTH-1:0];
            end
            if (!r_tags[i].valid) begin
                w_has_free  = 1'b1;
                w_free_slot = i[CHWIDTH-1:0];
            end
        end
    end

    assign w_victim       = w_has_free ? w_free_slot : r_rr_ptr;
    assign w_victim_dirty = r_tags[w_victim].valid && r_tags[w_victim].dirty;
    // ACTs that arrive mid-transfer are dropped; the timing FSM is frozen then.
    assign w_hit_evt      = w_act_evt && (r_state == IDLE) && w_hit;
    assign w_miss_evt     = w_act_evt && (r_state == IDLE) && !w_hit;
    assign w_fill_done    = i_ack && (r_state == FILL);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_miss_evt) w_state_nxt = w_victim_dirty ? WB : FILL;
            WB:   if (i_ack)      w_state_nxt = FILL;
            FILL: if (i_ack)      w_state_nxt = IDLE;
            default:              w_state_nxt = IDLE;
        endcase
    end

    // Output logic. The payload is stable for the whole WB or FILL phase.
    always_comb begin
        o_req     = (r_state != IDLE);
        o_wb      = (r_state == WB);
        o_row     = (r_state == WB) ? r_wb_row : r_row;
        o_slot    = r_slot;
        o_crow_id = r_crow_id;
        o_stall   = r_stall;
`ifdef MEMSYNC_PERF_EN
        o_hit     = w_hit_evt;
        o_miss    = w_miss_evt;
        o_wb_done = i_ack && (r_state == WB);
`endif
    end

    // Tag table, victim pointer, open-row tracking and transfer payload
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_chrows; i++) begin
                r_tags[i] <= '0;
            end
            r_rr_ptr     <= '0;
            r_slot       <= '0;
            r_crow_id    <= '0;
            r_row        <= '0;
            r_wb_row     <= '0;
            r_prev_fsm   <= '0;
            r_open       <= 1'b0;
            r_close_pend <= 1'b0;
            r_stall      <= 1'b0;
        end else begin
            r_prev_fsm <= i_bank_fsm;

            if (w_hit_evt) begin
                r_crow_id <= w_hit_slot;
                r_open    <= 1'b1;
            end

            if (w_miss_evt) begin
                r_row        <= i_row_id;
                r_slot       <= w_victim;
                r_wb_row     <= r_tags[w_victim].row;
                r_stall      <= 1'b1;
                r_open       <= 1'b0;
                r_close_pend <= 1'b0;
                // The pointer only advances when it actually supplied the victim.
                if (!w_has_free) begin
                    r_rr_ptr <= r_rr_ptr + 1'b1;
                end
            end

            if ((r_state == IDLE) && w_is_pr) begin
                r_open <= 1'b0;
            end

            // A precharge during a transfer is remembered and applied at fill end.
            if ((r_state != IDLE) && w_is_pr) begin
                r_close_pend <= 1'b1;
            end

            if ((r_state == IDLE) && w_is_wr && r_open) begin
                r_tags[r_crow_id].dirty <= 1'b1;
            end

            if (w_fill_done) begin
                r_tags[r_slot] <= '{valid: 1'b1, dirty: 1'b0, row: r_row};
                r_crow_id      <= r_slot;
                r_open         <= !(r_close_pend || w_is_pr);
                r_close_pend   <= 1'b0;
                r_stall        <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_sync_ctrl
// Purpose  : Per-bank DRAM-row to row-cache-slot mapping with a shared
//            backing-store sync channel. One mem_sync_bank per bank; this
//            level holds the bank arbiter, the payload mux and the stall OR.
// Ports    : clk, reset_n          clock, async active-low reset
//            RowId, BankFSM        per-bank row address / timing-FSM state
//            cRowId                per-bank open cache slot
//            stall                 OR of all bank stalls
//            sync_req/wb/bank/row/slot  transfer request and payload
//            sync_ack              one-cycle completion pulse
//            perf_hits/misses/wbs  saturating event counters, present only
//                                  when MEMSYNC_PERF_EN is defined
// Config   : MEMSYNC_PERF_EN  adds the perf_* counters and outputs
// Revision : 1.0  initial release
// ============================================================================
module mem_sync_ctrl
    import mem_sync_pkg::*;
#(
    parameter int BGWIDTH   = 2,
    parameter int BAWIDTH   = 2,
    parameter int CHWIDTH   = 5,
    parameter int ADDRWIDTH = c_row_w,
    parameter int ARB_RR    = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [ADDRWIDTH-1:0]         RowId   [2**BGWIDTH][2**BAWIDTH],
    input  logic [4:0]                   BankFSM [2**BGWIDTH][2**BAWIDTH],
    output logic [CHWIDTH-1:0]           cRowId  [2**BGWIDTH][2**BAWIDTH],
    output logic                         stall,
    output logic                         sync_req,
    output logic                         sync_wb,
    output logic [BGWIDTH+BAWIDTH-1:0]   sync_bank,
    output logic [ADDRWIDTH-1:0]         sync_row,
    output logic [CHWIDTH-1:0]           sync_slot,
    input  logic                         sync_ack
`ifdef MEMSYNC_PERF_EN
    ,
    output logic [31:0]                  perf_hits,
    output logic [31:0]                  perf_misses,
    output logic [31:0]                  perf_wbs
`endif
);

    localparam int c_bgs    = 2**BGWIDTH;
    localparam int c_bpg    = 2**BAWIDTH;
    localparam int c_nbanks = c_bgs * c_bpg;
    localparam int c_bw     = BGWIDTH + BAWIDTH;

    logic [c_nbanks-1:0]  w_req;
    logic [c_nbanks-1:0]  w_wb;
    logic [c_nbanks-1:0]  w_stall;
    logic [c_nbanks-1:0]  w_ack;
    logic [ADDRWIDTH-1:0] w_row  [c_nbanks];
    logic [CHWIDTH-1:0]   w_slot [c_nbanks];
`ifdef MEMSYNC_PERF_EN
    logic [c_nbanks-1:0]  w_hit_v;
    logic [c_nbanks-1:0]  w_miss_v;
    logic [c_nbanks-1:0]  w_wbd_v;
`endif

    logic                 r_busy;
    logic [c_bw-1:0]      r_gnt;
    logic [c_bw-1:0]      r_ptr;
    logic                 w_pick_vld;
    logic [c_bw-1:0]      w_pick;
    logic [c_bw-1:0]      w_base;
    logic [c_bw-1:0]      w_cand;

    for (genvar g = 0; g < c_bgs; g++) begin : g_bg
        for (genvar a = 0; a < c_bpg; a++) begin : g_ba
            localparam int c_idx = g * c_bpg + a;
            mem_sync_bank #(
                .CHWIDTH   (CHWIDTH),
                .ADDRWIDTH (ADDRWIDTH)
            ) u_bank (
                .clk        (clk),
                .reset_n    (reset_n),
                .i_row_id   (RowId[g][a]),
                .i_bank_fsm (BankFSM[g][a]),
                .i_ack      (w_ack[c_idx]),
                .o_req      (w_req[c_idx]),
                .o_wb       (w_wb[c_idx]),
                .o_row      (w_row[c_idx]),
                .o_slot     (w_slot[c_idx]),
                .o_crow_id  (cRowId[g][a]),
                .o_stall    (w_stall[c_idx])
`ifdef MEMSYNC_PERF_EN
                ,
                .o_hit      (w_hit_v[c_idx]),
                .o_miss     (w_miss_v[c_idx]),
                .o_wb_done  (w_wbd_v[c_idx])
`endif
            );
        end
    end

    // Arbiter pick: scan from the pointer (or from bank 0 in fixed-priority
    // mode); the descending loop leaves the nearest requester as the winner.
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        w_base     = (ARB_RR != 0) ? r_ptr : '0;
        w_cand     = '0;
        for (int k = c_nbanks - 1; k >= 0; k--) begin
            w_cand = w_base + k[c_bw-1:0];
            if (w_req[w_cand]) begin
                w_pick_vld = 1'b1;
                w_pick     = w_cand;
            end
        end
    end

    // Grant is held until ack; a new grant can only be taken while idle, so
    // there is always at least one idle cycle between transfers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
            r_gnt  <= '0;
            r_ptr  <= '0;
        end else if (r_busy) begin
            if (sync_ack) begin
                r_busy <= 1'b0;
                r_ptr  <= r_gnt + 1'b1;
            end
        end else if (w_pick_vld) begin
            r_busy <= 1'b1;
            r_gnt  <= w_pick;
        end
    end

    // An ack with no transfer outstanding reaches no bank.
    always_comb begin
        for (int i = 0; i < c_nbanks; i++) begin
            w_ack[i] = r_busy && sync_ack && (r_gnt == i[c_bw-1:0]);
        end
    end

    always_comb begin
        sync_req  = r_busy;
        sync_wb   = r_busy && w_wb[r_gnt];
        sync_bank = r_busy ? r_gnt : '0;
        sync_row  = r_busy ? w_row[r_gnt] : '0;
        sync_slot = r_busy ? w_slot[r_gnt] : '0;
        stall     = |w_stall;
    end

`ifdef MEMSYNC_PERF_EN
    // Several banks may report an event in the same cycle, so add the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_hits   <= '0;
            perf_misses <= '0;
            perf_wbs    <= '0;
        end else begin
            perf_hits   <= sat_add32(perf_hits,   32'($countones(w_hit_v)));
            perf_misses <= sat_add32(perf_misses, 32'($countones(w_miss_v)));
            perf_wbs    <= sat_add32(perf_wbs,    32'($countones(w_wbd_v)));
        end
    end
`endif

endmodule
`default_nettype wire
